// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the registered immediate generator: format select
// codes and the skid-buffer state encoding.
package imm_pkg;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_SH  = 3'b110;
    localparam logic [2:0] IMM_ILL = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Valid/ready bundle between decode and the immediate generator.
// The slave modport is the generator; the master modport is its producer and consumer.
interface imm_extend_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [24:0]       in_instr;
    logic [2:0]        in_immsrc;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic [TAG_W-1:0]  out_tag;
    logic              out_illegal;

    modport slave (
        input  in_valid, in_instr, in_immsrc, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_immsrc, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_extend_pipe_decode.sv
// Combinational RISC-V immediate decoder. instr_i carries instruction bits
// [31:7], so instruction bit k sits at instr_i[k-7].
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]     instr_i,
    input  logic [2:0]      immsrc_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);
    localparam int SH_W = (XLEN == 64) ? 6 : 5;

    logic [31:0] imm32_s;

    // Assemble the 32-bit immediate; bit 31 is the sign source for widening
    always_comb begin
        imm32_s   = 32'd0;
        illegal_o = 1'b0;
        case (immsrc_i)
            IMM_I:   imm32_s = {{20{instr_i[24]}}, instr_i[24:13]};
            IMM_S:   imm32_s = {{20{instr_i[24]}}, instr_i[24:18], instr_i[4:0]};
            IMM_B:   imm32_s = {{19{instr_i[24]}}, instr_i[24], instr_i[0],
                                instr_i[23:18], instr_i[4:1], 1'b0};
            IMM_J:   imm32_s = {{11{instr_i[24]}}, instr_i[24], instr_i[12:5],
                                instr_i[13], instr_i[23:14], 1'b0};
            IMM_U:   imm32_s = {instr_i[24:5], 12'd0};
            IMM_Z:   imm32_s = {27'd0, instr_i[12:8]};
            IMM_SH:  imm32_s[SH_W-1:0] = instr_i[13 +: SH_W];
            IMM_ILL: illegal_o = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

    // Z and SH leave bit 31 clear, so one sign-widening covers every format
    always_comb begin
        imm_o       = {XLEN{imm32_s[31]}};
        imm_o[31:0] = imm32_s;
    end
endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator with a 2-entry skid buffer so the upstream
// ready never depends combinationally on downstream ready.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int SKID  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    imm_extend_pipe_if.slave bus
);
    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $fatal(1, "imm_extend_pipe: XLEN must be 32 or 64");
    end

    skid_state_e      state_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [XLEN-1:0]  main_imm_q;
    logic [TAG_W-1:0] main_tag_q;
    logic             main_ill_q;
    logic [XLEN-1:0]  skid_imm_q;
    logic [TAG_W-1:0] skid_tag_q;
    logic             skid_ill_q;

    logic [XLEN-1:0]  dec_imm_s;
    logic             dec_ill_s;
    logic             in_ready_s;
    logic             accept_s;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (bus.in_instr),
        .immsrc_i  (bus.in_immsrc),
        .imm_o     (dec_imm_s),
        .illegal_o (dec_ill_s)
    );

    if (SKID != 0) begin : g_skid_ready
        assign in_ready_s = in_ready_q;
    end else begin : g_pass_ready
        assign in_ready_s = !out_valid_q || bus.out_ready;
    end

    assign accept_s        = bus.in_valid && in_ready_s;
    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = main_imm_q;
    assign bus.out_tag     = main_tag_q;
    assign bus.out_illegal = main_ill_q;

    // Skid FSM; flush wins over both input accept and output transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            main_imm_q  <= '0;
            main_tag_q  <= '0;
            main_ill_q  <= 1'b0;
            skid_imm_q  <= '0;
            skid_tag_q  <= '0;
            skid_ill_q  <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (accept_s) begin
                        main_imm_q  <= dec_imm_s;
                        main_tag_q  <= bus.in_tag;
                        main_ill_q  <= dec_ill_s;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    in_ready_q <= 1'b1;
                    if (accept_s && bus.out_ready) begin
                        main_imm_q <= dec_imm_s;
                        main_tag_q <= bus.in_tag;
                        main_ill_q <= dec_ill_s;
                    end else if (accept_s) begin
                        skid_imm_q <= dec_imm_s;
                        skid_tag_q <= bus.in_tag;
                        skid_ill_q <= dec_ill_s;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_TWO;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (bus.out_ready) begin
                        main_imm_q <= skid_imm_q;
                        main_tag_q <= skid_tag_q;
                        main_ill_q <= skid_ill_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_EMPTY;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: an RV32 and an RV64 instance on a shared
// clock/reset, checking decode values, latency, backpressure, flush and reset.
module tb_imm_extend_pipe;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.XLEN(32), .TAG_W(32)) ifa ();
    imm_extend_pipe_if #(.XLEN(64), .TAG_W(32)) ifb ();

    imm_extend_pipe #(.XLEN(32), .TAG_W(32), .SKID(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifa.slave));
    imm_extend_pipe #(.XLEN(64), .TAG_W(32), .SKID(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifb.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put_a(input logic [31:0] ins, input logic [2:0] src, input logic [31:0] tag);
        ifa.in_valid  = 1'b1;
        ifa.in_instr  = ins[31:7];
        ifa.in_immsrc = src;
        ifa.in_tag    = tag;
    endtask

    task automatic put_b(input logic [31:0] ins, input logic [2:0] src, input logic [31:0] tag);
        ifb.in_valid  = 1'b1;
        ifb.in_instr  = ins[31:7];
        ifb.in_immsrc = src;
        ifb.in_tag    = tag;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_instr = 25'd0; ifa.in_immsrc = 3'd0;
        ifa.in_tag = 32'd0;  ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_instr = 25'd0; ifb.in_immsrc = 3'd0;
        ifb.in_tag = 32'd0;  ifb.out_ready = 1'b1;

        #12;
        chk("rst_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst_imm", 64'(ifa.out_imm), 64'd0);
        chk("rst_tag", 64'(ifa.out_tag), 64'd0);
        chk("rst_ill", 64'(ifa.out_illegal), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        cyc();
        chk("ready_after_rst", 64'(ifa.in_ready), 64'd1);

        // I-type, one-cycle latency
        put_a(32'hFFF00093, 3'b000, 32'h100);
        chk("i_not_yet", 64'(ifa.out_valid), 64'd0);
        cyc();
        ifa.in_valid = 1'b0;
        chk("i_valid", 64'(ifa.out_valid), 64'd1);
        chk("i_imm", 64'(ifa.out_imm), 64'h0000_0000_FFFF_FFFF);
        chk("i_ill", 64'(ifa.out_illegal), 64'd0);
        chk("i_tag", 64'(ifa.out_tag), 64'h100);
        cyc();
        chk("i_drain", 64'(ifa.out_valid), 64'd0);

        // B, J, S, Z, illegal back to back
        put_a(32'hFE000EE3, 3'b010, 32'h104);
        cyc();
        put_a(32'h0010006F, 3'b011, 32'h108);
        chk("b_imm", 64'(ifa.out_imm), 64'h0000_0000_FFFF_FFFC);
        chk("b_tag", 64'(ifa.out_tag), 64'h104);
        cyc();
        put_a(32'hFE112E23, 3'b001, 32'h10C);
        chk("j_valid", 64'(ifa.out_valid), 64'd1);
        chk("j_imm", 64'(ifa.out_imm), 64'h800);
        chk("j_tag", 64'(ifa.out_tag), 64'h108);
        cyc();
        put_a(32'h000F8073, 3'b101, 32'h110);
        chk("s_imm", 64'(ifa.out_imm), 64'h0000_0000_FFFF_FFFC);
        cyc();
        put_a(32'hFFFFFFFF, 3'b111, 32'h114);
        chk("z_imm", 64'(ifa.out_imm), 64'h1F);
        cyc();
        ifa.in_valid = 1'b0;
        chk("ill32_imm", 64'(ifa.out_imm), 64'd0);
        chk("ill32_flag", 64'(ifa.out_illegal), 64'd1);
        cyc();
        chk("burst_drain", 64'(ifa.out_valid), 64'd0);

        // Backpressure: two fill the pipe, third waits
        ifa.out_ready = 1'b0;
        put_a(32'h00100093, 3'b000, 32'hA1);
        cyc();
        chk("bp1_ready", 64'(ifa.in_ready), 64'd1);
        chk("bp1_imm", 64'(ifa.out_imm), 64'd1);
        put_a(32'h00200093, 3'b000, 32'hA2);
        cyc();
        chk("bp2_ready", 64'(ifa.in_ready), 64'd0);
        chk("bp2_imm", 64'(ifa.out_imm), 64'd1);
        put_a(32'h00300093, 3'b000, 32'hA3);
        cyc();
        chk("bp3_ready", 64'(ifa.in_ready), 64'd0);
        chk("bp3_imm", 64'(ifa.out_imm), 64'd1);
        chk("bp3_tag", 64'(ifa.out_tag), 64'hA1);
        chk("bp3_valid", 64'(ifa.out_valid), 64'd1);
        ifa.out_ready = 1'b1;
        cyc();
        chk("bp_out2_imm", 64'(ifa.out_imm), 64'd2);
        chk("bp_out2_tag", 64'(ifa.out_tag), 64'hA2);
        cyc();
        ifa.in_valid = 1'b0;
        chk("bp_out3_imm", 64'(ifa.out_imm), 64'd3);
        chk("bp_out3_tag", 64'(ifa.out_tag), 64'hA3);
        cyc();
        chk("bp_drain", 64'(ifa.out_valid), 64'd0);

        // Flush from TWO with a concurrent input
        ifa.out_ready = 1'b0;
        put_a(32'h00100093, 3'b000, 32'hB1);
        cyc();
        put_a(32'h00200093, 3'b000, 32'hB2);
        cyc();
        put_a(32'h00300093, 3'b000, 32'hB3);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        ifa.in_valid = 1'b0;
        chk("fl_valid", 64'(ifa.out_valid), 64'd0);
        chk("fl_ready", 64'(ifa.in_ready), 64'd1);
        ifa.out_ready = 1'b1;
        cyc();
        chk("fl_dropped", 64'(ifa.out_valid), 64'd0);

        // Flush from EMPTY while in_ready is high
        put_a(32'h00400093, 3'b000, 32'hB4);
        flush = 1'b1;
        chk("fl2_ready", 64'(ifa.in_ready), 64'd1);
        cyc();
        flush = 1'b0;
        ifa.in_valid = 1'b0;
        chk("fl2_dropped", 64'(ifa.out_valid), 64'd0);

        // RV64: U, shamt, illegal at full throughput
        put_b(32'h800000B7, 3'b100, 32'h200);
        cyc();
        put_b(32'h03F0D093, 3'b110, 32'h204);
        chk("u64_valid", 64'(ifb.out_valid), 64'd1);
        chk("u64_imm", ifb.out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("u64_tag", 64'(ifb.out_tag), 64'h200);
        cyc();
        put_b(32'h12345678, 3'b111, 32'h208);
        chk("sh64_imm", ifb.out_imm, 64'h3F);
        chk("sh64_ill", 64'(ifb.out_illegal), 64'd0);
        cyc();
        ifb.in_valid = 1'b0;
        chk("ill64_imm", ifb.out_imm, 64'd0);
        chk("ill64_flag", 64'(ifb.out_illegal), 64'd1);
        chk("ill64_tag", 64'(ifb.out_tag), 64'h208);
        cyc();
        chk("b64_drain", 64'(ifb.out_valid), 64'd0);

        // Asynchronous reset between edges with data held
        ifa.out_ready = 1'b0;
        put_a(32'hFFF00093, 3'b000, 32'hC1);
        cyc();
        ifa.in_valid = 1'b0;
        chk("ar_pre_valid", 64'(ifa.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(ifa.out_valid), 64'd0);
        chk("ar_imm", 64'(ifa.out_imm), 64'd0);
        chk("ar_tag", 64'(ifa.out_tag), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        ifa.out_ready = 1'b1;
        cyc();
        chk("ar_ready", 64'(ifa.in_ready), 64'd1);
        chk("ar_empty", 64'(ifa.out_valid), 64'd0);
        put_a(32'h0010006F, 3'b011, 32'hC2);
        cyc();
        ifa.in_valid = 1'b0;
        chk("ar_lat_valid", 64'(ifa.out_valid), 64'd1);
        chk("ar_lat_imm", 64'(ifa.out_imm), 64'h800);
        chk("ar_lat_tag", 64'(ifa.out_tag), 64'hC2);
        cyc();
        chk("ar_drain", 64'(ifa.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
